// File: rtl/npu_inst_pkg.sv
// npu_inst_pkg: shared NPU instruction width, opcodes, control words and word builder
package npu_inst_pkg;

    localparam int NPU_INST_W = 128;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_MULT = 4'h4;
    localparam logic [3:0] OP_DOT  = 4'h6;
    localparam logic [3:0] OP_CONV = 4'h7;
    localparam logic [3:0] OP_POOL = 4'h8;
    localparam logic [3:0] OP_TANH = 4'hB;
    localparam logic [3:0] OP_GRAY = 4'hC;
    localparam logic [3:0] OP_TRAN = 4'hD;
    localparam logic [3:0] OP_ADDS = 4'hE;

    localparam logic [NPU_INST_W-1:0] INST_END     = 128'd0;
    localparam logic [NPU_INST_W-1:0] INST_RESTART = 128'd1;
    localparam logic [NPU_INST_W-1:0] INST_START   = 128'd2;

    function automatic logic [NPU_INST_W-1:0] mk_inst(input logic [3:0] op, input logic [31:0] a0,
                                                      input logic [31:0] a1, input logic [31:0] a2,
                                                      input logic [27:0] shape);
        return {op, a0, a1, a2, shape};
    endfunction

endpackage

// File: rtl/npu_inst_sequencer_if.sv
// npu_inst_sequencer_if: host push channel and npu_inst_join/fsm issue channel
interface npu_inst_sequencer_if import npu_inst_pkg::*; #(parameter int INST_W = NPU_INST_W);

    logic [INST_W-1:0] s_inst;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [INST_W-1:0] npu_inst;
    logic              npu_inst_en;
    logic              npu_inst_ready;

    modport master (output s_inst, s_last, s_valid, npu_inst_ready,
                    input  s_ready, npu_inst, npu_inst_en);
    modport slave  (input  s_inst, s_last, s_valid, npu_inst_ready,
                    output s_ready, npu_inst, npu_inst_en);

endinterface

// File: rtl/npu_inst_seq_fifo.sv
// npu_inst_seq_fifo: synchronous FIFO with flush and occupancy count
module npu_inst_seq_fifo #(
    parameter int W     = 129,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q];
    assign full    = count_q == CNTW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;

    // pointer and occupancy update; flush drops everything including a same-cycle push
    always_comb begin
        wptr_d  = flush ? '0 : wptr_q + AW'(do_push);
        rptr_d  = flush ? '0 : rptr_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CNTW'(do_push) - CNTW'(do_pop);
    end

    // storage array, written only for accepted pushes
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q] <= wdata;
    end

    // pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/npu_inst_sequencer.sv
// npu_inst_sequencer: queues host instruction batches and replays RESTART, words, END, START per batch
module npu_inst_sequencer import npu_inst_pkg::*; #(
    parameter int INST_W  = NPU_INST_W,
    parameter int DEPTH   = 16,
    parameter int GAP     = 1,
    parameter int BUSY_TO = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    npu_inst_sequencer_if.slave   bus,
    input  logic                  flush,
    output logic                  busy,
    output logic                  batch_done,
    output logic [15:0]           batch_cnt,
    output logic                  err_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BUSY_TO + GAP + 2);
    localparam logic [INST_W-1:0] W_RESTART = INST_W'(INST_RESTART);
    localparam logic [INST_W-1:0] W_END     = INST_W'(INST_END);
    localparam logic [INST_W-1:0] W_START   = INST_W'(INST_START);

    typedef enum logic [2:0] {
        S_IDLE, S_RESTART, S_LOAD, S_END, S_START, S_WAIT_BUSY, S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     last_cnt_q, last_cnt_d;
    logic              last_seen_q, last_seen_d;
    logic [INST_W-1:0] hold_q, hold_d;
    logic              batch_done_q, batch_done_d;
    logic [15:0]       batch_cnt_q, batch_cnt_d;
    logic              err_q, err_d;

    logic [INST_W:0]   f_rdata;
    logic              f_full, f_empty, f_push, pop, emit, gap_done;
    logic [AW:0]       f_count;
    logic [INST_W-1:0] word;

    npu_inst_seq_fifo #(.W(INST_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (f_push),
        .wdata ({bus.s_last, bus.s_inst}),
        .pop   (pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    // first cycle of every issuing state is the strobe; the rest of the state is the gap
    assign emit     = (state_q inside {S_RESTART, S_LOAD, S_END, S_START}) && cnt_q == '0 && !flush;
    assign gap_done = cnt_q == CW'(GAP);
    assign pop      = emit && state_q == S_LOAD && !f_empty;
    assign f_push   = bus.s_valid && bus.s_ready;
    assign word     = (state_q == S_RESTART) ? W_RESTART :
                      (state_q == S_LOAD)    ? f_rdata[INST_W-1:0] :
                      (state_q == S_END)     ? W_END : W_START;

    assign bus.s_ready     = (!f_full || pop) && !flush;
    assign bus.npu_inst    = emit ? word : hold_q;
    assign bus.npu_inst_en = emit;
    assign busy            = state_q != S_IDLE;
    assign batch_done      = batch_done_q;
    assign batch_cnt       = batch_cnt_q;
    assign err_timeout     = err_q;

    // next-state, gap/timeout counter and batch bookkeeping; flush overrides everything
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_seen_d  = pop ? f_rdata[INST_W] : last_seen_q;
        hold_d       = emit ? word : hold_q;
        last_cnt_d   = last_cnt_q + LW'(f_push && bus.s_last) - LW'(pop && f_rdata[INST_W]);
        batch_done_d = 1'b0;
        batch_cnt_d  = batch_cnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                state_d = (last_cnt_q != '0 && f_count != '0 && bus.npu_inst_ready) ? S_RESTART : S_IDLE;
            end
            S_RESTART: begin
                cnt_d   = gap_done ? '0 : cnt_q + 1'b1;
                state_d = gap_done ? S_LOAD : S_RESTART;
            end
            S_LOAD: begin
                cnt_d   = gap_done ? '0 : cnt_q + 1'b1;
                state_d = (gap_done && last_seen_q) ? S_END : S_LOAD;
            end
            S_END: begin
                cnt_d   = gap_done ? '0 : cnt_q + 1'b1;
                state_d = gap_done ? S_START : S_END;
            end
            S_START: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = gap_done ? S_WAIT_BUSY : S_START;
            end
            S_WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (!bus.npu_inst_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TO - 1)) begin
                    err_d        = 1'b1;
                    batch_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.npu_inst_ready) begin
                    batch_done_d = 1'b1;
                    batch_cnt_d  = batch_cnt_q + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            last_cnt_d   = '0;
            batch_done_d = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_cnt_q   <= '0;
            last_seen_q  <= 1'b0;
            hold_q       <= '0;
            batch_done_q <= 1'b0;
            batch_cnt_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_cnt_q   <= last_cnt_d;
            last_seen_q  <= last_seen_d;
            hold_q       <= hold_d;
            batch_done_q <= batch_done_d;
            batch_cnt_q  <= batch_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_npu_inst_sequencer.sv
// tb_npu_inst_sequencer: scoreboard bench for batch replay, backpressure, timeout, flush and reset
module tb_npu_inst_sequencer;
    import npu_inst_pkg::*;

    localparam int W = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy, batch_done, err_timeout;
    logic [15:0] batch_cnt;

    npu_inst_sequencer_if #(.INST_W(W)) bus_if ();

    npu_inst_sequencer #(.INST_W(W), .DEPTH(16), .GAP(1), .BUSY_TO(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .flush       (flush),
        .busy        (busy),
        .batch_done  (batch_done),
        .batch_cnt   (batch_cnt),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int vec = 0, miss = 0, cyc = 0, en_total = 0, done_cnt = 0, done_t = 0, rdy_mode = 0, rcnt = -1;
    logic [W-1:0] exp_q[$];
    int           en_t[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_en"}, bus_if.npu_inst_en, 0);
        chk({tag, "_inst"}, bus_if.npu_inst, 0);
        chk({tag, "_s_ready"}, bus_if.s_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, batch_done, 0);
        chk({tag, "_cnt"}, batch_cnt, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic l);
        int n = 0;
        bus_if.s_inst  = w;
        bus_if.s_last  = l;
        bus_if.s_valid = 1'b1;
        while (!bus_if.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", bus_if.s_ready, 1);
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.s_last  = 1'b0;
    endtask

    task automatic push_batch(input logic [W-1:0] ws[$]);
        exp_q.push_back(INST_RESTART);
        foreach (ws[i]) exp_q.push_back(ws[i]);
        exp_q.push_back(INST_END);
        exp_q.push_back(INST_START);
        foreach (ws[i]) push_word(ws[i], i == ws.size() - 1);
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", done_cnt >= target, 1);
        @(negedge clk);
    endtask

    task automatic wait_en(input int target, input int bound);
        int n = 0;
        while (en_total < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        chk("en_wait", en_total >= target, 1);
    endtask

    initial begin
        logic [W-1:0] q[$];
        int dc, base, en0;
        bus_if.s_inst = '0;
        bus_if.s_last = 1'b0;
        bus_if.s_valid = 1'b0;
        bus_if.npu_inst_ready = 1'b1;
        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(negedge clk);
                if (bus_if.npu_inst_en) begin
                    en_total++;
                    en_t.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        vec++;
                        miss++;
                        $display("FAIL unexpected_en: got %0h, expected no strobe", bus_if.npu_inst);
                    end else begin
                        chk("npu_inst", bus_if.npu_inst, exp_q.pop_front());
                    end
                end
                if (batch_done) begin
                    done_cnt++;
                    done_t = cyc;
                end
            end
            forever begin
                @(negedge clk);
                if (rst) rcnt = -1;
                else if (rdy_mode == 0 && bus_if.npu_inst_en && bus_if.npu_inst == INST_START) rcnt = 0;
                else if (rcnt >= 0) rcnt++;
                if (rcnt >= 53) rcnt = -1;
                bus_if.npu_inst_ready = !(rcnt >= 3);
            end
        join_none

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // single CONV batch: strobes every 2 cycles, one batch_done
        en_t.delete();
        q = '{mk_inst(OP_CONV, 32'h1000, 32'h2000, 32'h3000, 28'h0403030)};
        push_batch(q);
        wait_done(1, 300);
        chk("t1_en_count", en_t.size(), 4);
        if (en_t.size() >= 4) begin
            chk("t1_gap0", en_t[1] - en_t[0], 2);
            chk("t1_gap1", en_t[2] - en_t[1], 2);
            chk("t1_gap2", en_t[3] - en_t[2], 2);
        end
        repeat (5) @(negedge clk);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_batch_cnt", batch_cnt, 1);
        chk("t1_err", err_timeout, 0);

        // three back-to-back batches of 2, 1 and 3 words
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dc = done_cnt;
        q = '{mk_inst(OP_ADD, 32'h10, 32'h20, 32'h30, 28'h1), mk_inst(OP_MULT, 32'h11, 32'h21, 32'h31, 28'h2)};
        push_batch(q);
        q = '{mk_inst(OP_DOT, 32'h12, 32'h22, 32'h32, 28'h3)};
        push_batch(q);
        q = '{mk_inst(OP_POOL, 32'h13, 32'h23, 32'h33, 28'h4), mk_inst(OP_TANH, 32'h14, 32'h24, 32'h34, 28'h5),
              mk_inst(OP_GRAY, 32'h15, 32'h25, 32'h35, 28'h6)};
        push_batch(q);
        wait_done(dc + 3, 1500);
        chk("t2_batch_cnt", batch_cnt, 3);
        chk("t2_exp_empty", exp_q.size(), 0);

        // fill with 16 non-last words: full, no batch start, then flush empties it
        for (int i = 0; i < 16; i++) push_word(mk_inst(OP_ADDI, i, i + 1, i + 2, 28'h7), 1'b0);
        chk("t3_full_s_ready", bus_if.s_ready, 0);
        repeat (10) @(negedge clk);
        chk("t3_no_restart", busy, 0);
        flush = 1'b1;
        #1;
        chk("t3_flush_s_ready", bus_if.s_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t3_after_s_ready", bus_if.s_ready, 1);
        chk("t3_after_busy", busy, 0);
        dc = done_cnt;
        q = '{mk_inst(OP_TRAN, 32'h40, 32'h41, 32'h42, 28'h8)};
        push_batch(q);
        wait_done(dc + 1, 300);
        chk("t3_exp_empty", exp_q.size(), 0);

        // ready stuck high: timeout at START+64
        rdy_mode = 1;
        base = batch_cnt;
        dc = done_cnt;
        en_t.delete();
        q = '{mk_inst(OP_ADDS, 32'h50, 32'h51, 32'h52, 28'h9)};
        push_batch(q);
        wait_done(dc + 1, 300);
        chk("t4_err", err_timeout, 1);
        chk("t4_idle", busy, 0);
        chk("t4_batch_cnt", batch_cnt, base);
        if (en_t.size() >= 4) chk("t4_timeout_cycles", done_t - en_t[3], 64);
        else chk("t4_en_count", en_t.size(), 4);

        // flush during LOAD after the second word
        en0 = en_total;
        exp_q.push_back(INST_RESTART);
        exp_q.push_back(mk_inst(OP_CONV, 32'h60, 32'h61, 32'h62, 28'hA));
        exp_q.push_back(mk_inst(OP_CONV, 32'h63, 32'h64, 32'h65, 28'hB));
        push_word(mk_inst(OP_CONV, 32'h60, 32'h61, 32'h62, 28'hA), 1'b0);
        push_word(mk_inst(OP_CONV, 32'h63, 32'h64, 32'h65, 28'hB), 1'b0);
        push_word(mk_inst(OP_CONV, 32'h66, 32'h67, 32'h68, 28'hC), 1'b0);
        push_word(mk_inst(OP_CONV, 32'h69, 32'h6A, 32'h6B, 28'hD), 1'b1);
        wait_en(en0 + 3, 100);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_idle", busy, 0);
        chk("t5_err_kept", err_timeout, 1);
        chk("t5_cnt_kept", batch_cnt, base);
        chk("t5_exp_empty", exp_q.size(), 0);
        rdy_mode = 0;
        dc = done_cnt;
        q = '{mk_inst(OP_DOT, 32'h70, 32'h71, 32'h72, 28'hE)};
        push_batch(q);
        wait_done(dc + 1, 300);
        chk("t5_recover_cnt", batch_cnt, base + 1);

        // reset while waiting for npu_inst_ready to return
        en0 = en_total;
        dc = done_cnt;
        q = '{mk_inst(OP_POOL, 32'h80, 32'h81, 32'h82, 28'hF)};
        push_batch(q);
        wait_en(en0 + 4, 100);
        repeat (10) @(negedge clk);
        chk("t6_busy_wait", busy, 1);
        chk("t6_pre_cnt_nonzero", batch_cnt != 0, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_reset");
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("t6_no_done", done_cnt, dc);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
